// File: rtl/led_blink_arb.sv
// Round-robin arbiter that lends one board LED to four requesters and plays
// back each winner's burst of blinks as timed ON/OFF phases followed by a GAP.
module led_blink_arb #(
    parameter int   TICK_CYC  = 50000,
    parameter int   ON_TICKS  = 250,
    parameter int   OFF_TICKS = 250,
    parameter int   GAP_TICKS = 1000,
    parameter logic LED_ACT   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [15:0] blinks,
    input  logic        abort,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        busy,
    output logic        led
);

    localparam int PW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_CYC - 1);
    localparam logic [15:0]   ON_LAST  = 16'(ON_TICKS - 1);
    localparam logic [15:0]   OFF_LAST = 16'(OFF_TICKS - 1);
    localparam logic [15:0]   GAP_LAST = 16'(GAP_TICKS - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ON   = 2'd1;
    localparam logic [1:0] ST_OFF  = 2'd2;
    localparam logic [1:0] ST_GAP  = 2'd3;

    logic [1:0]    state;
    logic [1:0]    ptr;
    logic [1:0]    owner;
    logic [3:0]    rem;
    logic [PW-1:0] pre;
    logic [15:0]   phase;

    logic          found;
    logic [1:0]    win;
    logic [1:0]    idx;
    logic [3:0]    win_blinks;
    logic [15:0]   cur_last;
    logic          tick;
    logic          phase_end;

    // Search req from the rr pointer upward with wrap; first hit wins.
    always_comb begin
        found = 1'b0;
        win   = ptr;
        idx   = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    assign win_blinks = blinks[{win, 2'b00} +: 4];

    always_comb begin
        case (state)
            ST_ON:   cur_last = ON_LAST;
            ST_OFF:  cur_last = OFF_LAST;
            default: cur_last = GAP_LAST;
        endcase
    end

    assign tick      = (pre == PRE_LAST);
    assign phase_end = tick && (phase == cur_last);

    // Counters are cleared on every state change so each phase starts fresh.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            ptr   <= 2'd0;
            owner <= 2'd0;
            rem   <= 4'd0;
            pre   <= '0;
            phase <= 16'd0;
            gnt   <= 4'd0;
            done  <= 4'd0;
            busy  <= 1'b0;
            led   <= ~LED_ACT;
        end else begin
            done <= 4'd0;
            if (state == ST_IDLE) begin
                pre   <= '0;
                phase <= 16'd0;
                if (found) begin
                    rem <= win_blinks;
                    if (win_blinks != 4'd0) begin
                        gnt   <= 4'b0001 << win;
                        busy  <= 1'b1;
                        led   <= LED_ACT;
                        owner <= win;
                        state <= ST_ON;
                    end else begin
                        done <= 4'b0001 << win;
                        ptr  <= win + 2'd1;
                    end
                end
            end else if (abort) begin
                gnt   <= 4'd0;
                busy  <= 1'b0;
                led   <= ~LED_ACT;
                ptr   <= owner + 2'd1;
                pre   <= '0;
                phase <= 16'd0;
                state <= ST_IDLE;
            end else if (phase_end) begin
                pre   <= '0;
                phase <= 16'd0;
                if (state == ST_ON) begin
                    rem <= rem - 4'd1;
                    led <= ~LED_ACT;
                    // The final blink is followed by GAP instead of OFF.
                    state <= (rem != 4'd1) ? ST_OFF : ST_GAP;
                end else if (state == ST_OFF) begin
                    led   <= LED_ACT;
                    state <= ST_ON;
                end else begin
                    done  <= gnt;
                    gnt   <= 4'd0;
                    busy  <= 1'b0;
                    ptr   <= owner + 2'd1;
                    state <= ST_IDLE;
                end
            end else begin
                pre <= tick ? '0 : pre + 1'b1;
                if (tick) begin
                    phase <= phase + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_led_blink_arb.sv
// Self-checking bench for led_blink_arb: a timeline model derived from burst
// arithmetic checks every cycle, plus directed scenarios with literal values.
module tb_led_blink_arb;

    localparam int TICK_CYC  = 4;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 1;
    localparam int GAP_TICKS = 3;
    localparam int ON_CYC    = ON_TICKS * TICK_CYC;
    localparam int OFF_CYC   = OFF_TICKS * TICK_CYC;
    localparam int GAP_CYC   = GAP_TICKS * TICK_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = 4'd0;
    logic [15:0] blinks = 16'd0;
    logic        abort = 1'b0;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        busy;
    logic        led;

    int n_compared = 0;
    int n_mismatched = 0;

    led_blink_arb #(
        .TICK_CYC (TICK_CYC),
        .ON_TICKS (ON_TICKS),
        .OFF_TICKS(OFF_TICKS),
        .GAP_TICKS(GAP_TICKS),
        .LED_ACT  (1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .blinks(blinks),
        .abort (abort),
        .gnt   (gnt),
        .done  (done),
        .busy  (busy),
        .led   (led)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] r, input logic [15:0] b, input logic a);
        req    = r;
        blinks = b;
        abort  = a;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        apply_stimulus(4'd0, 16'd0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Timeline model: a burst of n blinks granted at edge 0 is lit during
    // cycles where e % (ON+OFF) < ON, and ends after n*ON+(n-1)*OFF+GAP cycles.
    bit       m_active = 1'b0;
    int       m_owner = 0;
    int       m_n = 0;
    int       m_e = 0;
    int       m_ptr = 0;
    logic [3:0] m_done = 4'd0;

    function automatic int burst_len(input int n);
        return n * ON_CYC + (n - 1) * OFF_CYC + GAP_CYC;
    endfunction

    function automatic logic model_led();
        if (!m_active) return 1'b0;
        if (m_e >= m_n * ON_CYC + (m_n - 1) * OFF_CYC) return 1'b0;
        return ((m_e % (ON_CYC + OFF_CYC)) < ON_CYC);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 1'b0;
            m_owner  = 0;
            m_n      = 0;
            m_e      = 0;
            m_ptr    = 0;
            m_done   = 4'd0;
        end else begin
            m_done = 4'd0;
            if (m_active) begin
                m_e++;
                if (abort) begin
                    m_active = 1'b0;
                    m_ptr    = (m_owner + 1) % 4;
                end else if (m_e == burst_len(m_n)) begin
                    m_done   = 4'(1 << m_owner);
                    m_active = 1'b0;
                    m_ptr    = (m_owner + 1) % 4;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    int i;
                    i = (m_ptr + k) % 4;
                    if (req[i]) begin
                        if (blinks[i*4 +: 4] == 4'd0) begin
                            m_done = 4'(1 << i);
                            m_ptr  = (i + 1) % 4;
                        end else begin
                            m_active = 1'b1;
                            m_owner  = i;
                            m_n      = int'(blinks[i*4 +: 4]);
                            m_e      = 0;
                        end
                        break;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        check_output("model_gnt", 16'(gnt), m_active ? 16'(1 << m_owner) : 16'd0);
        check_output("model_done", 16'(done), 16'(m_done));
        check_output("model_busy", 16'(busy), 16'(m_active));
        check_output("model_led", 16'(led), 16'(model_led()));
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    logic [3:0] g_hist [0:84];

    initial begin
        $display("[TB] starting led_blink_arb scenarios");
        #1;
        check_output("reset_gnt", 16'(gnt), 16'd0);
        check_output("reset_led", 16'(led), 16'd0);
        check_output("reset_busy", 16'(busy), 16'd0);

        // Single burst of two blinks for requester 0.
        apply_reset();
        apply_stimulus(4'b0001, 16'h0002, 1'b0);
        @(negedge clk);
        check_output("t1_gnt_rise", 16'(gnt), 16'h1);
        check_output("t1_led_first", 16'(led), 16'h1);
        apply_stimulus(4'b0000, 16'h0002, 1'b0);
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            case (k)
                7:  check_output("t1_led_k7", 16'(led), 16'h1);
                8:  check_output("t1_led_k8", 16'(led), 16'h0);
                11: check_output("t1_led_k11", 16'(led), 16'h0);
                12: check_output("t1_led_k12", 16'(led), 16'h1);
                19: check_output("t1_led_k19", 16'(led), 16'h1);
                20: check_output("t1_led_k20", 16'(led), 16'h0);
                31: check_output("t1_gnt_k31", 16'(gnt), 16'h1);
                32: begin
                    check_output("t1_done_k32", 16'(done), 16'h1);
                    check_output("t1_gnt_k32", 16'(gnt), 16'h0);
                    check_output("t1_busy_k32", 16'(busy), 16'h0);
                end
                33: check_output("t1_done_k33", 16'(done), 16'h0);
                default: ;
            endcase
        end

        // Round-robin with all four requesting single blinks.
        apply_reset();
        apply_stimulus(4'b1111, 16'h1111, 1'b0);
        for (int k = 0; k <= 84; k++) begin
            @(negedge clk);
            g_hist[k] = gnt;
        end
        apply_stimulus(4'b0000, 16'h1111, 1'b0);
        for (int j = 0; j < 4; j++) begin
            check_output("t2_gnt_start", 16'(g_hist[21*j]), 16'(1 << j));
            check_output("t2_gnt_hold", 16'(g_hist[21*j + 19]), 16'(1 << j));
            check_output("t2_gnt_idle", 16'(g_hist[21*j + 20]), 16'h0);
        end
        check_output("t2_gnt_wrap", 16'(g_hist[84]), 16'h1);
        repeat (22) @(negedge clk);

        // Zero-count request: done only, then search resumes at requester 3.
        apply_reset();
        apply_stimulus(4'b0100, 16'h0000, 1'b0);
        @(negedge clk);
        check_output("t3_done", 16'(done), 16'h4);
        check_output("t3_gnt", 16'(gnt), 16'h0);
        check_output("t3_led", 16'(led), 16'h0);
        apply_stimulus(4'b1001, 16'h1001, 1'b0);
        @(negedge clk);
        check_output("t3_next_gnt", 16'(gnt), 16'h8);
        apply_stimulus(4'b0000, 16'h1001, 1'b0);
        repeat (22) @(negedge clk);

        // Abort during OFF of a three-blink burst for requester 1.
        apply_reset();
        apply_stimulus(4'b0010, 16'h0030, 1'b0);
        @(negedge clk);
        check_output("t4_gnt", 16'(gnt), 16'h2);
        apply_stimulus(4'b0000, 16'h0030, 1'b0);
        repeat (10) @(negedge clk);
        apply_stimulus(4'b0000, 16'h0030, 1'b1);
        @(negedge clk);
        check_output("t4_abort_gnt", 16'(gnt), 16'h0);
        check_output("t4_abort_led", 16'(led), 16'h0);
        check_output("t4_abort_done", 16'(done), 16'h0);
        apply_stimulus(4'b0011, 16'h0031, 1'b0);
        @(negedge clk);
        check_output("t4_regrant", 16'(gnt), 16'h1);
        apply_stimulus(4'b0000, 16'h0031, 1'b0);
        repeat (22) @(negedge clk);

        // Abort in the final GAP cycle suppresses done.
        apply_reset();
        apply_stimulus(4'b0001, 16'h0001, 1'b0);
        @(negedge clk);
        apply_stimulus(4'b0000, 16'h0001, 1'b0);
        repeat (19) @(negedge clk);
        check_output("t5_gnt_last", 16'(gnt), 16'h1);
        apply_stimulus(4'b0000, 16'h0001, 1'b1);
        @(negedge clk);
        check_output("t5_done", 16'(done), 16'h0);
        check_output("t5_gnt", 16'(gnt), 16'h0);
        apply_stimulus(4'b0000, 16'h0001, 1'b0);
        @(negedge clk);
        check_output("t5_done_after", 16'(done), 16'h0);

        // Asynchronous reset during ON of a five-blink burst.
        apply_reset();
        apply_stimulus(4'b0100, 16'h0500, 1'b0);
        @(negedge clk);
        check_output("t6_gnt", 16'(gnt), 16'h4);
        apply_stimulus(4'b0000, 16'h0500, 1'b0);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_output("t6_rst_led", 16'(led), 16'h0);
        check_output("t6_rst_gnt", 16'(gnt), 16'h0);
        check_output("t6_rst_done", 16'(done), 16'h0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(4'b0101, 16'h0101, 1'b0);
        @(negedge clk);
        check_output("t6_regrant", 16'(gnt), 16'h1);
        apply_stimulus(4'b0000, 16'h0101, 1'b0);
        repeat (22) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/led_blink_arb.md
Name: led_blink_arb

Overview:
- Shares one board LED between four requesters, e.g. status, error, heartbeat and debug sources.
- Each requester asks for a burst of N blinks. The block grants the LED round-robin, then sequences the ON/OFF/GAP timing for that burst.
- Timing is derived from a prescaled tick: TICK_CYC clock cycles per tick, 1 ms at 50 MHz by default.
- The block sits between the status sources and the LED pin and replaces per-source free-running blink counters.

Parameters:
- TICK_CYC, 50000: clock cycles per tick; must be ≥2.
- ON_TICKS, 250: ticks the LED is active per blink; range 1..255.
- OFF_TICKS, 250: ticks the LED is inactive between blinks of one burst; range 1..255.
- GAP_TICKS, 1000: ticks the LED is inactive after the last blink, before release; range 1..65535.
- LED_ACT, 1'b1: LED output level meaning "lit".

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: asynchronous active-low reset.
- req, input, 4: level request per requester; bit 0..3.
- blinks, input, 16: blink count per requester; bits [4i+3:4i] belong to requester i; sampled at grant.
- abort, input, 1: synchronous cancel of the current burst.
- gnt, output, 4: one-hot grant; all zero when idle.
- done, output, 4: one-cycle pulse on the granted bit when a burst completes normally.
- busy, output, 1: high whenever gnt is nonzero.
- led, output, 1: LED drive.

Behaviour:
- Reset (async, rst_n=0): gnt=0, done=0, busy=0, led=~LED_ACT, state=IDLE, rr pointer=0, prescaler and phase counters=0.
- States: IDLE, ON, OFF, GAP.
- Phase length: each phase lasts exactly (phase_TICKS × TICK_CYC) clock cycles. The prescaler and phase counter restart on every state entry.

IDLE:
- Arbitrate among req bits, searching from the rr pointer upward with wrap: ptr, ptr+1, … mod 4.
- If a winner i is found, at the next edge: gnt[i]=1, busy=1, rem=blinks[i] is latched.
  - If rem≠0: state=ON, led=LED_ACT.
  - If rem=0: no LED activity and no GAP. done[i] pulses on that same edge, gnt stays 0, rr pointer=i+1, state stays IDLE.
- Minimum one IDLE cycle between consecutive bursts.

ON:
- At phase end, rem is decremented.
- If rem was >1: state=OFF, led inactive.
- If rem was 1: state=GAP, led inactive. GAP replaces the final OFF.

OFF:
- At phase end: state=ON, led=LED_ACT.

GAP:
- At phase end, on the same edge: done[i]=1 for one cycle, gnt=0, busy=0, state=IDLE, rr pointer=(i+1) mod 4.

Request handling:
- req is level-sensitive and sampled only in IDLE.
- Deasserting req[i] during its own burst has no effect; the burst completes.
- A requester still asserting req after its done pulse has lowest priority in the next arbitration.
- blinks changes after grant are ignored.

abort:
- Highest priority; acts in any non-IDLE state.
- At the next edge: gnt=0, busy=0, led inactive, state=IDLE, rr pointer=(i+1) mod 4, no done pulse.
- Abort coinciding with a phase end: abort wins and no done pulse is produced.
- Abort in IDLE: ignored; arbitration in that cycle proceeds normally.

Outputs and widths:
- All outputs are registered; led never glitches.
- Prescaler width is $clog2(TICK_CYC). Phase counter is 16 bits. rem is 4 bits.
- Counters saturate-free: they are always reloaded on phase entry and never wrap mid-phase.

Reset mid-burst:
- Returns immediately to reset values.
- No done pulse; the burst is lost.

Test Plan:
Parameters for all scenarios: TICK_CYC=4, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3, which gives ON=8, OFF=4, GAP=12 cycles.
1. Single burst: req=0001, blinks[3:0]=2.
   - gnt=0001 one edge later.
   - led lit 8, dark 4, lit 8, dark 12.
   - done=0001 and gnt=0 exactly 32 cycles after gnt rose; busy mirrors gnt.
2. Round-robin: req=1111 held, all blinks=1.
   - Grants occur in order 0001, 0010, 0100, 1000, 0001.
   - Each grant holds for 20 cycles, with 1 IDLE cycle between grants.
3. Zero count: req=0100, blinks[11:8]=0.
   - done=0100 pulses one cycle after the request.
   - gnt stays 0 and led never lights.
   - The next grant search starts at requester 3.
4. Abort: start a burst of 3 for requester 1, assert abort in cycle 10 (during OFF).
   - Next edge: gnt=0, led dark, no done.
   - req=0011 then grants requester 0 first, since the rr pointer moved to 2 and wraps past the idle requesters 2 and 3.
5. Abort at phase end: abort asserted in the last GAP cycle.
   - No done pulse; state returns to IDLE.
6. Reset mid-ON: rst_n low for 3 cycles during ON of a burst of 5.
   - led=~LED_ACT, gnt=0, done=0 immediately (async).
   - After release, re-arbitration starts from requester 0.
